// File: rtl/sigmoid_ctrl_pkg.sv
// sigmoid_ctrl_pkg
// Shared types and helpers for the sigmoid round-robin arbiter.
//   DATA_W_DEF : default sample width (matches pwla_sigmoid)
//   RR_MAX     : largest supported requester count
//   RR_IDX_W   : index width wide enough for RR_MAX requesters
//   tag_t      : per-stage tag {valid, originating requester index}
//   rr_pick    : round-robin one-hot picker over a padded request vector
package sigmoid_ctrl_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int RR_MAX     = 16;
   localparam int RR_IDX_W   = 4;

   // idx is sized for the largest arbiter; narrower arbiters zero-extend.
   typedef struct packed {
      logic                valid;
      logic [RR_IDX_W-1:0] idx;
   } tag_t;

   // Returns a one-hot vector selecting the first set bit of valid_vec at or
   // after ptr, wrapping modulo n. Bits at positions >= n are never selected,
   // so non-power-of-2 requester counts wrap correctly.
   function automatic logic [RR_MAX-1:0] rr_pick(
      input logic [RR_MAX-1:0]   valid_vec,
      input logic [RR_IDX_W-1:0] ptr,
      input logic [RR_IDX_W:0]   n
   );
      logic [RR_MAX-1:0] pick;
      logic              found;
      logic [RR_IDX_W:0] k;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < RR_MAX; i++) begin
         // ptr < n and i < n, so a single conditional subtract is a full mod
         k = {1'b0, ptr} + (RR_IDX_W+1)'(i);
         if (k >= n) k = k - n;
         if (!found && ((RR_IDX_W+1)'(i) < n) && valid_vec[k[RR_IDX_W-1:0]]) begin
            pick[k[RR_IDX_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant
// Combinational round-robin grant with a registered rotation pointer.
//   clk, reset      : clock, synchronous active-high reset (pointer -> 0)
//   i_enable        : 0 suppresses all grants
//   i_req_valid     : per-requester request
//   o_grant         : one-hot grant (combinational)
//   o_grant_idx     : binary index of the granted requester
//   o_grant_any     : a grant (and therefore a handshake) happens this cycle
module rr_grant
   import sigmoid_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_enable,
   input  logic [NUM_REQ-1:0] i_req_valid,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_grant_any
);

   logic [IDX_W-1:0]    r_ptr;
   logic [RR_MAX-1:0]   w_vld_full;
   logic [RR_MAX-1:0]   w_pick_full;
   logic [RR_IDX_W-1:0] w_ptr_ext;

   // Grants are masked while in reset so req_ready stays low then.
   always_comb begin
      w_vld_full = '0;
      if (i_enable && !reset) w_vld_full[NUM_REQ-1:0] = i_req_valid;
   end

   assign w_ptr_ext   = RR_IDX_W'(r_ptr);
   assign w_pick_full = rr_pick(w_vld_full, w_ptr_ext, (RR_IDX_W+1)'(NUM_REQ));

   generate
      if (NUM_REQ < RR_MAX) begin : g_trim
         // Padding bits are zero so the picker never lands there; folding
         // them in keeps the upper result bits from dangling.
         logic w_spill;
         assign w_spill = |w_pick_full[RR_MAX-1:NUM_REQ];
         assign o_grant = w_spill ? '0 : w_pick_full[NUM_REQ-1:0];
      end else begin : g_full
         assign o_grant = w_pick_full;
      end
   endgenerate

   always_comb begin
      o_grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (o_grant[i]) o_grant_idx = IDX_W'(i);
      end
   end

   assign o_grant_any = |o_grant;

   // Pointer moves to the requester just after the winner, wrapping at NUM_REQ.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (o_grant_any) begin
         if (o_grant_idx == IDX_W'(NUM_REQ-1)) r_ptr <= '0;
         else                                  r_ptr <= o_grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/sigmoid_rr_arbiter.sv
// sigmoid_rr_arbiter
// Shares one fixed-latency pwla_sigmoid between NUM_REQ requesters. One sample
// is accepted per cycle by round-robin, registered onto sig_x, and tagged with
// its requester index. The tag travels a SIG_LATENCY+1 stage pipe so that the
// last stage lines up with sig_f_x for that sample, routing the result back.
//   clk, reset : clock, synchronous active-high reset
//   enable     : 0 = no new grants; in-flight samples still drain
//   req_valid  : per-requester request
//   req_x      : flattened samples, requester i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot grant (combinational)
//   sig_x      : registered drive to pwla_sigmoid.x
//   sig_f_x    : pwla_sigmoid.f_x
//   rsp_valid  : one-hot response strobe
//   rsp_f_x    : response data (0 when no response)
//   idle       : no sample in flight
module sigmoid_rr_arbiter
   import sigmoid_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SIG_LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_x,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         sig_x,
   input  logic [DATA_W-1:0]         sig_f_x,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_f_x,
   output logic                      idle
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_grant_idx;
   logic                w_hs;
   logic [DATA_W-1:0]   w_sel_x;
   logic [RR_IDX_W-1:0] w_idx_ext;
   logic                w_any_vld;
   tag_t                w_last;

   logic [DATA_W-1:0]   r_sig_x;
   tag_t                r_tag [SIG_LATENCY+1];

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_grant (
      .clk         (clk),
      .reset       (reset),
      .i_enable    (enable),
      .i_req_valid (req_valid),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_grant_any (w_hs)
   );

   assign req_ready = w_grant;

   // One-hot AND-OR select of the granted sample.
   always_comb begin
      w_sel_x = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) w_sel_x = w_sel_x | req_x[i*DATA_W +: DATA_W];
      end
   end

   assign w_idx_ext = RR_IDX_W'(w_grant_idx);

   // sig_x only moves on a handshake, so the sigmoid input is quiet otherwise.
   always_ff @(posedge clk) begin
      if (reset)     r_sig_x <= '0;
      else if (w_hs) r_sig_x <= w_sel_x;
   end

   assign sig_x = r_sig_x;

   // Tag pipe shifts every cycle; clearing it on reset drops in-flight samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s <= SIG_LATENCY; s++) r_tag[s] <= '0;
      end else begin
         r_tag[0] <= w_hs ? '{valid: 1'b1, idx: w_idx_ext} : '0;
         for (int s = 1; s <= SIG_LATENCY; s++) r_tag[s] <= r_tag[s-1];
      end
   end

   assign w_last = r_tag[SIG_LATENCY];

   always_comb begin
      rsp_valid = '0;
      if (w_last.valid) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_last.idx == RR_IDX_W'(i)) rsp_valid[i] = 1'b1;
         end
      end
   end

   assign rsp_f_x = w_last.valid ? sig_f_x : '0;

   always_comb begin
      w_any_vld = 1'b0;
      for (int s = 0; s <= SIG_LATENCY; s++) w_any_vld = w_any_vld | r_tag[s].valid;
   end

   assign idle = !w_any_vld;

endmodule

// File: tb/tb_sigmoid_rr_arbiter.sv
module tb_sigmoid_rr_arbiter;
   localparam int N  = 4;
   localparam int N3 = 3;
   localparam int DW = 16;
   localparam int L  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- 4-requester DUT ----------------
   logic            reset, enable;
   logic [N-1:0]    req_valid, req_ready, rsp_valid;
   logic [N*DW-1:0] req_x;
   logic [DW-1:0]   sig_x, sig_f_x, rsp_f_x;
   logic            idle;

   sigmoid_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SIG_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid), .req_x(req_x),
      .req_ready(req_ready), .sig_x(sig_x), .sig_f_x(sig_f_x), .rsp_valid(rsp_valid),
      .rsp_f_x(rsp_f_x), .idle(idle));

   // Sigmoid stub: f_x = x + 0x0100 after L edges
   logic [DW-1:0] f_pipe [L];
   always @(posedge clk) begin
      f_pipe[0] <= sig_x + 16'h0100;
      for (int k = 1; k < L; k++) f_pipe[k] <= f_pipe[k-1];
   end
   assign sig_f_x = f_pipe[L-1];

   // ---------------- 3-requester DUT (wrap check) ----------------
   logic             reset3, enable3;
   logic [N3-1:0]    req_valid3, req_ready3, rsp_valid3;
   logic [N3*DW-1:0] req_x3;
   logic [DW-1:0]    sig_x3, sig_f_x3, rsp_f_x3;
   logic             idle3;

   sigmoid_rr_arbiter #(.NUM_REQ(N3), .DATA_W(DW), .SIG_LATENCY(L)) dut3 (
      .clk(clk), .reset(reset3), .enable(enable3), .req_valid(req_valid3), .req_x(req_x3),
      .req_ready(req_ready3), .sig_x(sig_x3), .sig_f_x(sig_f_x3), .rsp_valid(rsp_valid3),
      .rsp_f_x(rsp_f_x3), .idle(idle3));

   logic [DW-1:0] f3_pipe [L];
   always @(posedge clk) begin
      f3_pipe[0] <= sig_x3 + 16'h0100;
      for (int k = 1; k < L; k++) f3_pipe[k] <= f3_pipe[k-1];
   end
   assign sig_f_x3 = f3_pipe[L-1];

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- reference model (4-requester DUT) ----------------
   // Pending responses as a queue of {due cycle, requester, expected f_x}.
   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] fx;
   } exp_t;
   exp_t          m_q[$];
   int            m_ptr = 0;
   logic [DW-1:0] m_sigx = '0;
   int            cyc = 0;

   function automatic logic [DW-1:0] x_of(input int i);
      return req_x[i*DW +: DW];
   endfunction

   // First valid requester at or after the pointer, or -1 when nothing is granted.
   function automatic int m_pick();
      if (reset || !enable) return -1;
      for (int k = 0; k < N; k++)
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   // Advance the model with the inputs the DUT samples at the coming edge,
   // then move to the next falling edge.
   task automatic adv();
      int g;
      g = m_pick();
      if (reset) begin
         m_q.delete();
         m_ptr  = 0;
         m_sigx = '0;
      end else if (g >= 0) begin
         m_q.push_back('{due: cyc + 1 + L, idx: g, fx: x_of(g) + 16'h0100});
         m_ptr  = (g + 1) % N;
         m_sigx = x_of(g);
      end
      while (m_q.size() > 0 && m_q[0].due <= cyc) void'(m_q.pop_front());
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      req_valid = '0;
      for (int i = 0; i < n; i++) adv();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; req_valid = 4'b1111; req_x = {$urandom, $urandom};
      adv();
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
      n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
      n_cmp++; if (sig_x !== 16'h0000) begin n_fail++; $display("FAIL reset_sig_x got=%h exp=0000", sig_x); end
      n_cmp++; if (rsp_f_x !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_f_x got=%h exp=0000", rsp_f_x); end
      adv();
      reset = 1'b0; req_valid = '0;
   endtask

   task automatic test_single();
      req_valid = 4'b0100; req_x = '0; req_x[2*DW +: DW] = 16'h0005;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
      adv();
      req_valid = '0;
      #1;
      n_cmp++; if (sig_x !== 16'h0005) begin n_fail++; $display("FAIL single_sig_x got=%h exp=0005", sig_x); end
      n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_t1 got=%b exp=0", idle); end
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_t1 got=%b exp=0000", rsp_valid); end
      adv(); #1;
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_t2 got=%b exp=0000", rsp_valid); end
      n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_t2 got=%b exp=0", idle); end
      adv(); #1;
      n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_t3 got=%b exp=0100", rsp_valid); end
      n_cmp++; if (rsp_f_x !== 16'h0105) begin n_fail++; $display("FAIL single_fx_t3 got=%h exp=0105", rsp_f_x); end
      adv(); #1;
      n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_t4 got=%b exp=1", idle); end
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_t4 got=%b exp=0000", rsp_valid); end
      adv();
   endtask

   task automatic test_contention();
      logic [N-1:0]  e_r;
      logic [DW-1:0] e_f;
      reset = 1'b1; req_valid = '0; adv(); reset = 1'b0;
      for (int i = 0; i < N; i++) req_x[i*DW +: DW] = 16'(16'h0010 * i);
      for (int k = 0; k < 11; k++) begin
         req_valid = (k < 8) ? 4'b1111 : 4'b0000;
         #1;
         if (k < 8) begin
            e_r = 4'(1 << (k % 4));
            n_cmp++; if (req_ready !== e_r) begin n_fail++; $display("FAIL contention_grant k=%0d got=%b exp=%b", k, req_ready, e_r); end
         end
         if (k >= 3) begin
            e_r = 4'(1 << ((k - 3) % 4));
            e_f = 16'(16'h0100 + 16'h0010 * ((k - 3) % 4));
            n_cmp++; if (rsp_valid !== e_r) begin n_fail++; $display("FAIL contention_rsp k=%0d got=%b exp=%b", k, rsp_valid, e_r); end
            n_cmp++; if (rsp_f_x !== e_f) begin n_fail++; $display("FAIL contention_fx k=%0d got=%h exp=%h", k, rsp_f_x, e_f); end
         end
         adv();
      end
      #1;
      n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL contention_idle got=%b exp=1", idle); end
   endtask

   task automatic test_fairness();
      reset = 1'b1; req_valid = '0; adv(); reset = 1'b0;
      req_valid = 4'b1000; #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL fair_first got=%b exp=1000", req_ready); end
      adv();
      req_valid = 4'b1001; #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fair_zero_first got=%b exp=0001", req_ready); end
      adv();
      req_valid = 4'b1000; #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL fair_three_next got=%b exp=1000", req_ready); end
      adv();
      drain(4);
   endtask

   task automatic test_enable();
      reset = 1'b1; req_valid = '0; adv(); reset = 1'b0;
      for (int i = 0; i < N; i++) req_x[i*DW +: DW] = 16'(16'h0020 + i);
      enable = 1'b1; req_valid = 4'b1111;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL en_grant0 got=%b exp=0001", req_ready); end
      adv(); #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL en_grant1 got=%b exp=0010", req_ready); end
      adv();
      enable = 1'b0;
      for (int c = 2; c < 7; c++) begin
         #1;
         n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_gated c=%0d got=%b exp=0000", c, req_ready); end
         if (c == 3) begin
            n_cmp++; if (rsp_valid !== 4'b0001 || rsp_f_x !== 16'h0120) begin n_fail++; $display("FAIL en_rsp0 got=%b/%h exp=0001/0120", rsp_valid, rsp_f_x); end
         end
         if (c == 4) begin
            n_cmp++; if (rsp_valid !== 4'b0010 || rsp_f_x !== 16'h0121) begin n_fail++; $display("FAIL en_rsp1 got=%b/%h exp=0010/0121", rsp_valid, rsp_f_x); end
            n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL en_busy got=%b exp=0", idle); end
         end
         if (c == 5) begin
            n_cmp++; if (idle !== 1'b1 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL en_idle got=%b/%b exp=1/0000", idle, rsp_valid); end
         end
         adv();
      end
      enable = 1'b1; req_valid = '0;
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; req_valid = '0; adv(); reset = 1'b0;
      req_valid = 4'b1111; req_x = {$urandom, $urandom};
      adv(); adv(); adv();
      reset = 1'b1; #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_ready_in_reset got=%b exp=0000", req_ready); end
      adv();
      reset = 1'b0; req_valid = '0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (rsp_valid !== 4'b0000 || rsp_f_x !== 16'h0000) begin n_fail++; $display("FAIL rmid_no_rsp c=%0d got=%b/%h exp=0000/0000", c, rsp_valid, rsp_f_x); end
         n_cmp++; if (idle !== 1'b1 || sig_x !== 16'h0000) begin n_fail++; $display("FAIL rmid_state c=%0d idle=%b sig_x=%h exp=1/0000", c, idle, sig_x); end
         adv();
      end
      req_valid = 4'b0101; #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr0 got=%b exp=0001", req_ready); end
      adv();
      drain(4);
   endtask

   task automatic test_wrap3();
      reset3 = 1'b1; enable3 = 1'b1; req_valid3 = '0; req_x3 = '0;
      @(negedge clk); reset3 = 1'b0;
      req_valid3 = 3'b100; req_x3[2*DW +: DW] = 16'h0007; #1;
      n_cmp++; if (req_ready3 !== 3'b100) begin n_fail++; $display("FAIL wrap3_g2 got=%b exp=100", req_ready3); end
      @(negedge clk);
      req_valid3 = 3'b101; req_x3[0 +: DW] = 16'h000A; #1;
      n_cmp++; if (req_ready3 !== 3'b001) begin n_fail++; $display("FAIL wrap3_g0 got=%b exp=001", req_ready3); end
      n_cmp++; if (sig_x3 !== 16'h0007) begin n_fail++; $display("FAIL wrap3_sig_x got=%h exp=0007", sig_x3); end
      @(negedge clk);
      req_valid3 = 3'b100; req_x3[2*DW +: DW] = 16'h000B; #1;
      n_cmp++; if (req_ready3 !== 3'b100) begin n_fail++; $display("FAIL wrap3_g2b got=%b exp=100", req_ready3); end
      @(negedge clk);
      req_valid3 = '0; #1;
      n_cmp++; if (rsp_valid3 !== 3'b100 || rsp_f_x3 !== 16'h0107) begin n_fail++; $display("FAIL wrap3_rsp0 got=%b/%h exp=100/0107", rsp_valid3, rsp_f_x3); end
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid3 !== 3'b001 || rsp_f_x3 !== 16'h010A) begin n_fail++; $display("FAIL wrap3_rsp1 got=%b/%h exp=001/010a", rsp_valid3, rsp_f_x3); end
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid3 !== 3'b100 || rsp_f_x3 !== 16'h010B) begin n_fail++; $display("FAIL wrap3_rsp2 got=%b/%h exp=100/010b", rsp_valid3, rsp_f_x3); end
      @(negedge clk);
      req_valid3 = 3'b110; #1;
      n_cmp++; if (idle3 !== 1'b1) begin n_fail++; $display("FAIL wrap3_idle got=%b exp=1", idle3); end
      n_cmp++; if (req_ready3 !== 3'b010) begin n_fail++; $display("FAIL wrap3_ptr_wrapped got=%b exp=010", req_ready3); end
      @(negedge clk);
      req_valid3 = '0;
   endtask

   task automatic test_random();
      int            g;
      logic [N-1:0]  e_ready, e_rv;
      logic [DW-1:0] e_fx;
      reset = 1'b1; req_valid = '0; adv();
      for (int c = 0; c < 400; c++) begin
         reset     = ($urandom_range(0, 49) == 0);
         enable    = ($urandom_range(0, 9) != 0);
         req_valid = N'($urandom_range(0, 15));
         req_x     = {$urandom, $urandom};
         #1;
         g = m_pick();
         e_ready = '0; if (g >= 0) e_ready[g] = 1'b1;
         e_rv = '0; e_fx = '0;
         if (m_q.size() > 0 && m_q[0].due == cyc) begin e_rv[m_q[0].idx] = 1'b1; e_fx = m_q[0].fx; end
         n_cmp++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
         n_cmp++; if (rsp_valid !== e_rv) begin n_fail++; $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, e_rv); end
         n_cmp++; if (rsp_f_x !== e_fx) begin n_fail++; $display("FAIL rand_rsp_f_x c=%0d got=%h exp=%h", c, rsp_f_x, e_fx); end
         n_cmp++; if (idle !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rand_idle c=%0d got=%b exp=%b", c, idle, (m_q.size() == 0)); end
         n_cmp++; if (sig_x !== m_sigx) begin n_fail++; $display("FAIL rand_sig_x c=%0d got=%h exp=%h", c, sig_x, m_sigx); end
         adv();
      end
      reset = 1'b0; enable = 1'b1;
      drain(4);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; req_valid = '0; req_x = '0;
      reset3 = 1'b1; enable3 = 1'b0; req_valid3 = '0; req_x3 = '0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_enable();
      test_reset_mid();
      test_wrap3();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sigmoid_rr_arbiter.md
Name: sigmoid_rr_arbiter

Overview:
Shares one pwla_sigmoid instance between NUM_REQ requesters (e.g. neuron lanes) using round-robin arbitration. Accepts at most one x per cycle, drives the sigmoid input, and tracks each in-flight sample in a tag pipeline. Routes each f_x back to its originating requester after a fixed latency. Sits directly in front of pwla_sigmoid; the sigmoid is fixed-latency and cannot stall.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
DATA_W, 16, width of x and f_x; matches pwla_sigmoid.
SIG_LATENCY, 2, clk edges from sig_x stable to sig_f_x reflecting it (≥1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
enable  in  1  1 = grants allowed; 0 = no new grants, in-flight samples still drain.
req_valid  in  NUM_REQ  per-requester request.
req_x  in  NUM_REQ*DATA_W  flattened inputs; requester i at [i*DATA_W +: DATA_W].
req_ready  out  NUM_REQ  one-hot grant; combinational.
sig_x  out  DATA_W  registered drive to pwla_sigmoid.x.
sig_f_x  in  DATA_W  from pwla_sigmoid.f_x.
rsp_valid  out  NUM_REQ  one-hot; result for requester i this cycle.
rsp_f_x  out  DATA_W  result data, shared by all requesters.
idle  out  1  1 when no sample is in flight.

Behaviour:
- Reset (sync, reset=1 at an edge): rr_ptr=0, sig_x=0, whole tag pipe invalid. rsp_valid=0, idle=1, rsp_f_x=0. req_ready=0 while reset is high. Samples in flight at reset are discarded; no rsp_valid is produced for them, even if sig_f_x later changes.
- Grant (combinational): if enable=1, grant the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … mod NUM_REQ. Set req_ready[i]=1 only for that i. req_ready=0 if enable=0 or no valid request.
- Handshake: req_valid[i] & req_ready[i] in cycle t. At that edge: sig_x <= slice i; tag stage 0 <= {valid=1, idx=i}; rr_ptr <= (i+1) mod NUM_REQ.
- No handshake in a cycle: sig_x holds its value; stage 0 <= invalid; rr_ptr holds.
- Requesters hold req_valid/req_x until accepted. The arbiter never assumes stability and samples only at handshake.
- Tag pipe: SIG_LATENCY+1 stages; shifts every cycle unconditionally.
- Response timing: sample accepted in cycle t has its last stage valid in cycle t+1+SIG_LATENCY.
  - rsp_valid = onehot(last.idx) if last.valid, else 0.
  - rsp_f_x = sig_f_x when last.valid, else 0 (combinational mux).
  - Total latency 1+SIG_LATENCY cycles. Throughput 1 sample/cycle; back-to-back grants to the same or different requesters are legal.
- idle = no stage valid (combinational OR-reduce, inverted).
- Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,… A requester waits at most NUM_REQ-1 cycles.
- enable falling mid-stream: no new grants from that cycle on. Responses for accepted samples still appear on schedule. idle rises the cycle after the last response.
- Only one requester valid: it is granted every cycle regardless of rr_ptr.
- rr_ptr wrap: (NUM_REQ-1)+1 wraps to 0. Non-power-of-2 NUM_REQ must wrap correctly; the bench checks NUM_REQ=3.

Decomposition:
- Package sigmoid_ctrl_pkg:
  - DATA_W default constant.
  - tag_t struct {logic valid; logic [$clog2(NUM_REQ)-1:0] idx}; index width via localparam in module if NUM_REQ is parameterised.
  - Function rr_pick(valid_vec, ptr) returning a one-hot vector.
- One sub-module is natural: rr_grant (combinational round-robin picker plus registered pointer). The tag pipe stays inline.

Test Plan:
- Stub for pwla_sigmoid: f_x = x + 16'h0100 after SIG_LATENCY edges. Also run once with the real pwla_sigmoid.
- Reset/single request: reset 1 cycle, then req_valid=4'b0100, x[2]=16'h0005. Expect req_ready=4'b0100 in the same cycle. sig_x=16'h0005 in the next cycle. rsp_valid=4'b0100 with rsp_f_x=16'h0105 exactly 3 cycles after the handshake. idle=0 in between, then 1.
- Full contention: all four valid for 8 cycles with x[i]=16'h0010*i. Expect grant order 0,1,2,3,0,1,2,3. Expect responses in the same order with f_x = 0x0100, 0x0110, 0x0120, 0x0130, repeated, one per cycle.
- Pointer fairness: requester 3 accepted, then requesters 0 and 3 both valid. Expect 0 granted before 3. Repeat with NUM_REQ=3 to check the wrap.
- enable gating: drop enable with 2 samples in flight and requests pending. Expect req_ready=0, both responses still delivered on schedule, then idle=1.
- Reset mid-operation: assert reset with 3 samples in flight. Expect rsp_valid=0 for all following cycles until new traffic, rr_ptr=0 (requesters 0 and 2 valid → 0 granted first), sig_x=0.
